// File: rtl/ula_issue_ctrl.sv
// ULA issue controller: decodes a MIPS-style request into ULA operands and select,
// captures the combinational ULA result and returns it on a valid/ready response port.
package ula_pkg;
    typedef logic [31:0] bus_type;

    typedef enum logic [2:0] {
        ULA_ADD  = 3'd0,
        ULA_SUB  = 3'd1,
        ULA_AND  = 3'd2,
        ULA_OR   = 3'd3,
        ULA_NOR  = 3'd4,
        ULA_SLT  = 3'd5,
        ULA_SLTU = 3'd6
    } ula_oper_type;
endpackage

module ula_issue_ctrl
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_funct,
    input  logic [WIDTH-1:0]  req_rs_val,
    input  logic [WIDTH-1:0]  req_rt_val,
    input  logic [15:0]       req_imm,
    output logic [WIDTH-1:0]  ula_a,
    output logic [WIDTH-1:0]  ula_b,
    output ula_oper_type      ula_sel,
    input  logic [WIDTH-1:0]  ula_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  ops_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              dec_legal;
    ula_oper_type      dec_sel;
    logic [WIDTH-1:0]  dec_b;
    logic [WIDTH-1:0]  imm_sext;
    logic [WIDTH-1:0]  imm_zext;

    assign imm_sext = {{(WIDTH-16){req_imm[15]}}, req_imm};
    assign imm_zext = {{(WIDTH-16){1'b0}}, req_imm};

    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = ULA_ADD;
        dec_b     = req_rt_val;
        case (req_opcode)
            6'h00: begin
                case (req_funct)
                    6'h20, 6'h21: dec_sel = ULA_ADD;
                    6'h22, 6'h23: dec_sel = ULA_SUB;
                    6'h24:        dec_sel = ULA_AND;
                    6'h25:        dec_sel = ULA_OR;
                    6'h27:        dec_sel = ULA_NOR;
                    6'h2A:        dec_sel = ULA_SLT;
                    6'h2B:        dec_sel = ULA_SLTU;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin dec_sel = ULA_ADD;  dec_b = imm_sext; end
            6'h0A:        begin dec_sel = ULA_SLT;  dec_b = imm_sext; end
            6'h0B:        begin dec_sel = ULA_SLTU; dec_b = imm_sext; end
            6'h0C:        begin dec_sel = ULA_AND;  dec_b = imm_zext; end
            6'h0D:        begin dec_sel = ULA_OR;   dec_b = imm_zext; end
            6'h04, 6'h05: begin dec_sel = ULA_SUB;  dec_b = req_rt_val; end
            default:      dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = dec_legal ? S_EXEC : S_RESP;
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Illegal requests leave ula_* and ops_count untouched; only the response fields change.
    always_ff @(posedge clk) begin
        if (reset) begin
            ula_a       <= '0;
            ula_b       <= '0;
            ula_sel     <= ULA_ADD;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            ops_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (dec_legal) begin
                            ula_a       <= req_rs_val;
                            ula_b       <= dec_b;
                            ula_sel     <= dec_sel;
                            rsp_illegal <= 1'b0;
                        end else begin
                            rsp_illegal <= 1'b1;
                            rsp_result  <= '0;
                            rsp_zero    <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_result <= ula_s;
                    rsp_zero   <= (ula_s == '0);
                    if (ops_count != '1) ops_count <= ops_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Directed bench for ula_issue_ctrl with a behavioural ULA closing the loop on ula_s.
module tb_ula_issue_ctrl;
    import ula_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [5:0]        req_funct;
    logic [WIDTH-1:0]  req_rs_val;
    logic [WIDTH-1:0]  req_rt_val;
    logic [15:0]       req_imm;
    logic [WIDTH-1:0]  ula_a;
    logic [WIDTH-1:0]  ula_b;
    ula_oper_type      ula_sel;
    logic [WIDTH-1:0]  ula_s;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_result;
    logic              rsp_zero;
    logic              rsp_illegal;
    logic [CNT_W-1:0]  ops_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ula_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_funct(req_funct),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val), .req_imm(req_imm),
        .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_s(ula_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .ops_count(ops_count)
    );

    // Environment ULA
    always_comb begin
        ula_s = '0;
        case (ula_sel)
            ULA_ADD:  ula_s = ula_a + ula_b;
            ULA_SUB:  ula_s = ula_a - ula_b;
            ULA_AND:  ula_s = ula_a & ula_b;
            ULA_OR:   ula_s = ula_a | ula_b;
            ULA_NOR:  ula_s = ~(ula_a | ula_b);
            ULA_SLT:  ula_s = {31'd0, ($signed(ula_a) < $signed(ula_b))};
            ULA_SLTU: ula_s = {31'd0, (ula_a < ula_b)};
            default:  ula_s = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; on return the accept edge has passed.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        req_opcode = op; req_funct = fn; req_rs_val = rs; req_rt_val = rt; req_imm = imm;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rel_valid", 32'(rsp_valid), 32'd0);
        chk("rel_ready", 32'(req_ready), 32'd1);
    endtask

    // Legal op: checks ULA drive in EXEC, then the response one cycle later.
    task automatic legal_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                            input logic [31:0] exp_b, input ula_oper_type exp_sel,
                            input logic [31:0] exp_res, input logic [15:0] exp_ops);
        issue(op, fn, rs, rt, imm);
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_a"}, ula_a, rs);
        chk({tag, "_b"}, ula_b, exp_b);
        chk({tag, "_sel"}, 32'(ula_sel), 32'(exp_sel));
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_result"}, rsp_result, exp_res);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(exp_res == 32'd0));
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'd0);
        chk({tag, "_ops"}, 32'(ops_count), 32'(exp_ops));
        release_rsp();
    endtask

    task automatic illegal_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] keep_a, input logic [31:0] keep_b,
                              input ula_oper_type keep_sel, input logic [15:0] keep_ops);
        issue(op, fn, 32'hDEAD_BEEF, 32'h0BAD_F00D, 16'h5555);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_illegal"}, 32'(rsp_illegal), 32'd1);
        chk({tag, "_result"}, rsp_result, 32'd0);
        chk({tag, "_zero"}, 32'(rsp_zero), 32'd0);
        chk({tag, "_a"}, ula_a, keep_a);
        chk({tag, "_b"}, ula_b, keep_b);
        chk({tag, "_sel"}, 32'(ula_sel), 32'(keep_sel));
        chk({tag, "_ops"}, 32'(ops_count), 32'(keep_ops));
        release_rsp();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_opcode = '0; req_funct = '0; req_rs_val = '0; req_rt_val = '0; req_imm = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", 32'(rsp_zero), 32'd0);
        chk("rst_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_a", ula_a, 32'd0);
        chk("rst_b", ula_b, 32'd0);
        chk("rst_sel", 32'(ula_sel), 32'(ULA_ADD));
        chk("rst_ops", 32'(ops_count), 32'd0);

        legal_op("add",  6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 32'd7, ULA_ADD, 32'd12, 16'd1);
        legal_op("beq",  6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0, 32'h1234, ULA_SUB, 32'd0, 16'd2);
        legal_op("slti", 6'h0A, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h0001, 32'h1, ULA_SLT, 32'd1, 16'd3);
        legal_op("andi", 6'h0C, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h8000, 32'h0000_8000, ULA_AND,
                 32'h0000_8000, 16'd4);
        illegal_op("ill_op", 6'h3F, 6'h00, 32'hFFFF_FFFF, 32'h0000_8000, ULA_AND, 16'd4);
        illegal_op("ill_fn", 6'h00, 6'h00, 32'hFFFF_FFFF, 32'h0000_8000, ULA_AND, 16'd4);
        legal_op("sltiu", 6'h0B, 6'h00, 32'd5, 32'd0, 16'hFFFF, 32'hFFFF_FFFF, ULA_SLTU, 32'd1, 16'd5);
        legal_op("sltu", 6'h00, 6'h2B, 32'd1, 32'hFFFF_FFFF, 16'h0, 32'hFFFF_FFFF, ULA_SLTU, 32'd1, 16'd6);
        legal_op("slt",  6'h00, 6'h2A, 32'd1, 32'hFFFF_FFFF, 16'h0, 32'hFFFF_FFFF, ULA_SLT, 32'd0, 16'd7);
        legal_op("nor",  6'h00, 6'h27, 32'hF0F0_0000, 32'h0000_0F0F, 16'h0, 32'h0000_0F0F, ULA_NOR,
                 32'h0F0F_F0F0, 16'd8);
        legal_op("ori",  6'h0D, 6'h00, 32'h0001_0000, 32'd0, 16'h8001, 32'h0000_8001, ULA_OR,
                 32'h0001_8001, 16'd9);

        // Backpressure: response held, a second request is presented but never taken.
        issue(6'h00, 6'h22, 32'd100, 32'd23, 16'h0);
        tick();
        req_opcode = 6'h00; req_funct = 6'h20; req_rs_val = 32'd9; req_rt_val = 32'd9;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_result", rsp_result, 32'd77);
            chk("bp_a", ula_a, 32'd100);
            chk("bp_sel", 32'(ula_sel), 32'(ULA_SUB));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
        chk("bp_rel_ready", 32'(req_ready), 32'd1);
        chk("bp_rel_a", ula_a, 32'd100);
        chk("bp_ops", 32'(ops_count), 32'd10);
        tick();
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_a", ula_a, 32'd100);

        // Reset while in EXEC drops the transaction.
        issue(6'h00, 6'h20, 32'd3, 32'd4, 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        chk("mrst_ops", 32'(ops_count), 32'd0);
        chk("mrst_a", ula_a, 32'd0);
        tick();
        chk("mrst_valid2", 32'(rsp_valid), 32'd0);
        chk("mrst_result", rsp_result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
